iobuf_dir_ctrl: RTL and testbench

//   Direction controller for a half-duplex bidirectional buffer pair (bufif1 A->B, bufif0 B->A).

---
 rtl/iobuf_dir_if.sv | 34 +++
 rtl/iobuf_dir_ctrl.sv | 149 ++++++++++++++
 tb/tb_iobuf_dir_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/iobuf_dir_if.sv
// Request/grant/enable bundle between the io endpoints and the direction controller.
// master: endpoints driving requests; slave: controller driving grants, enables and dir.
interface iobuf_dir_if;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic oe_a;
  logic oe_b;
  logic dir;
  logic busy;

  modport master (
    output req_a,
    output req_b,
    input  gnt_a,
    input  gnt_b,
    input  oe_a,
    input  oe_b,
    input  dir,
    input  busy
  );

  modport slave (
    input  req_a,
    input  req_b,
    output gnt_a,
    output gnt_b,
    output oe_a,
    output oe_b,
    output dir,
    output busy
  );
endinterface

// File: rtl/iobuf_dir_ctrl.sv
// Half-duplex direction controller: arbitrates A/B drive requests with a dead gap.
// Ports: clk, rst (sync, high), io (slave: req_a/b in; gnt_a/b, oe_a/b, dir, busy out).
module iobuf_dir_ctrl #(
  parameter int TURN_CYC = 3,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  iobuf_dir_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE_A,
    DRIVE_B,
    TURN
  } state_t;

  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TURNC = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] MINH  = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] MAXH  = CNT_W'(MAX_HOLD);
  localparam logic             REVOK = (MAX_HOLD != 0);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic [CNT_W-1:0] turn_q;
  logic [CNT_W-1:0] turn_d;
  logic             last_a_q;
  logic             last_a_d;
  logic             dir_q;
  logic             dir_d;
  logic             gnt_a_q;
  logic             gnt_b_q;
  logic             busy_q;

  logic             win_a;
  logic             win_b;
  logic             own_req;
  logic             oth_req;
  logic             rel;
  logic [CNT_W-1:0] hold_inc;
  logic [CNT_W-1:0] turn_inc;

  // Tie goes to the side that did not own the line last.
  assign win_a = io.req_a & (~io.req_b | ~last_a_q);
  assign win_b = io.req_b & (~io.req_a |  last_a_q);

  assign hold_inc = (hold_q == CMAX) ? hold_q : hold_q + ONE;
  assign turn_inc = (turn_q == CMAX) ? turn_q : turn_q + ONE;

  always_comb begin
    own_req = 1'b0;
    oth_req = 1'b0;
    if (state_q == DRIVE_A) begin
      own_req = io.req_a;
      oth_req = io.req_b;
    end else if (state_q == DRIVE_B) begin
      own_req = io.req_b;
      oth_req = io.req_a;
    end
  end

  // Voluntary release honours MIN_HOLD; forced release needs a waiting peer.
  assign rel = (~own_req & (hold_q >= MINH))
             | (REVOK & oth_req & (hold_q >= MAXH));

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    last_a_d = last_a_q;
    dir_d    = dir_q;
    unique case (state_q)
      IDLE, TURN: begin
        if (state_q == TURN && turn_q < TURNC) begin
          turn_d = turn_inc;
        end else begin
          turn_d = '0;
          unique case (1'b1)
            win_a: begin
              state_d = DRIVE_A;
              hold_d  = ONE;
              dir_d   = 1'b1;
            end
            win_b: begin
              state_d = DRIVE_B;
              hold_d  = ONE;
              dir_d   = 1'b0;
            end
            default: begin
              state_d = IDLE;
              hold_d  = '0;
            end
          endcase
        end
      end
      DRIVE_A, DRIVE_B: begin
        if (rel) begin
          state_d  = TURN;
          turn_d   = ONE;
          hold_d   = '0;
          last_a_d = (state_q == DRIVE_A);
        end else begin
          hold_d = hold_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      turn_q   <= '0;
      last_a_q <= 1'b0;
      dir_q    <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      last_a_q <= last_a_d;
      dir_q    <= dir_d;
      gnt_a_q  <= (state_d == DRIVE_A);
      gnt_b_q  <= (state_d == DRIVE_B);
      busy_q   <= (state_d != IDLE);
    end
  end

  // Enables share the grant flops so they can never disagree.
  assign io.gnt_a = gnt_a_q;
  assign io.gnt_b = gnt_b_q;
  assign io.oe_a  = gnt_a_q;
  assign io.oe_b  = gnt_b_q;
  assign io.dir   = dir_q;
  assign io.busy  = busy_q;

endmodule

// File: tb/tb_iobuf_dir_ctrl.sv
// Bench for iobuf_dir_ctrl: directed scenarios plus random requests.
// Compares every cycle against a timeline model and checks the drive invariants.
module tb_iobuf_dir_ctrl;
  localparam int TURN_CYC = 3;
  localparam int MIN_HOLD = 2;
  localparam int MAX_HOLD = 8;
  localparam int SAT      = 15;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  iobuf_dir_if io ();

  iobuf_dir_ctrl #(
    .TURN_CYC (TURN_CYC),
    .MIN_HOLD (MIN_HOLD),
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the line (0 none, 1 A, 2 B), how long, and the gap age.
  int   owner;
  int   age;
  int   gap;
  int   last;
  logic mdir;
  int   low_run;
  logic seen_owner;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic ra, input logic rb);
    if (ra && rb) return (last == 1) ? 2 : 1;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  task automatic model(input logic ra, input logic rb, input logic r);
    logic mine;
    logic other;
    int   w;
    if (r) begin
      owner = 0; age = 0; gap = 0; last = 2; mdir = 1'b0;
      return;
    end
    if (owner != 0) begin
      mine  = (owner == 1) ? ra : rb;
      other = (owner == 1) ? rb : ra;
      if ((!mine && age >= MIN_HOLD) ||
          (MAX_HOLD != 0 && other && age >= MAX_HOLD)) begin
        last  = owner;
        owner = 0;
        gap   = 1;
      end else if (age < SAT) begin
        age++;
      end
      return;
    end
    if (gap != 0 && gap < TURN_CYC) begin
      gap++;
      return;
    end
    w     = pick(ra, rb);
    gap   = 0;
    owner = w;
    age   = (w != 0) ? 1 : 0;
    if (w != 0) mdir = (w == 1);
  endtask

  task automatic step(input logic ra, input logic rb, input logic r);
    logic [7:0] got;
    logic [7:0] exp;
    io.req_a = ra;
    io.req_b = rb;
    rst      = r;
    @(posedge clk);
    model(ra, rb, r);
    @(negedge clk);
    got = {2'b0, io.gnt_a, io.gnt_b, io.oe_a, io.oe_b, io.dir, io.busy};
    exp = {2'b0, owner == 1, owner == 2, owner == 1, owner == 2, mdir,
           (owner != 0) || (gap != 0)};
    chk("outs", got, exp);
    chk("excl", {7'b0, io.oe_a & io.oe_b}, 8'h00);
    if (r) begin
      seen_owner = 1'b0;
      low_run    = 0;
    end else if (io.oe_a || io.oe_b) begin
      if (seen_owner && low_run > 0)
        chk("gap", {7'b0, low_run >= TURN_CYC}, 8'h01);
      seen_owner = 1'b1;
      low_run    = 0;
    end else begin
      low_run++;
    end
  endtask

  logic ra;
  logic rb;

  initial begin
    total = 0; bad = 0;
    seen_owner = 1'b0; low_run = 0;
    owner = 0; age = 0; gap = 0; last = 2; mdir = 1'b0;
    rst = 1'b1; io.req_a = 1'b0; io.req_b = 1'b0;
    @(negedge clk);

    // 1 and 2: A grant, B waits, A drops at cycle 5.
    step(0, 0, 1);
    chk("rst", {2'b0, io.gnt_a, io.gnt_b, io.oe_a, io.oe_b, io.dir, io.busy}, 8'h00);
    step(1, 0, 0);
    chk("t1", {2'b0, io.gnt_a, io.gnt_b, io.oe_a, io.oe_b, io.dir, io.busy}, 8'h2b);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("t2lo", {6'b0, io.oe_a, io.oe_b}, 8'h00);
    end
    step(0, 1, 0);
    chk("t2b", {5'b0, io.gnt_b, io.oe_b, io.dir}, 8'h06);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // 3: simultaneous after reset, A first then B.
    step(0, 0, 1);
    step(1, 1, 0);
    chk("t3a", {7'b0, io.gnt_a}, 8'h01);
    for (int i = 0; i < 8 + TURN_CYC; i++) step(1, 1, 0);
    chk("t3b", {7'b0, io.gnt_b}, 8'h01);

    // 4: one-cycle pulse held for MIN_HOLD.
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("t4h", {7'b0, io.gnt_a}, 8'h01);
    step(0, 0, 0);
    chk("t4r", {7'b0, io.gnt_a}, 8'h00);
    for (int i = 0; i < TURN_CYC; i++) step(0, 0, 0);
    chk("t4i", {7'b0, io.busy}, 8'h00);

    // 5: revoke after MAX_HOLD.
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 0);

    // 6: reset while B drives.
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("t6", {2'b0, io.gnt_a, io.gnt_b, io.oe_a, io.oe_b, io.dir, io.busy}, 8'h00);

    // Random level requests with rare resets.
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) ra = ~ra;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      step(ra, rb, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
